// File: rtl/seg_pkg.sv
// Shared state encodings, seven-segment table and round-robin helper for the
// segment display arbiter.
package seg_pkg;

    typedef logic [0:0] arb_state_t;
    localparam arb_state_t ARB_IDLE  = 1'b0;
    localparam arb_state_t ARB_GRANT = 1'b1;

    // Segment order {g,f,e,d,c,b,a}; the decimal point is handled separately.
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [3:0] DIGIT_ONEHOT [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    // First set bit of req at or above start (wrapping modulo n).
    function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] start,
                                           input int n);
        logic [1:0] pick;
        logic       found;
        int         idx;
        pick  = start;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = (int'(start) + i) % n;
            if (i < n && !found && req[idx[1:0]]) begin
                pick  = idx[1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Digit-scan timebase: prescaler, digit index, slot tick and frame boundary.
// Counters stay at zero while not running or when a restart is requested.
module seg_scan_timer #(
    parameter int SCAN_DIV = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       restart,
    output logic [1:0] digit,
    output logic       tick,
    output logic       frame_bnd
);
    localparam int PW = $clog2(SCAN_DIV);

    logic [PW-1:0] presc;

    assign tick      = run && (presc == PW'(SCAN_DIV - 1));
    assign frame_bnd = tick && (digit == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            digit <= '0;
        end else if (!run || restart) begin
            presc <= '0;
            digit <= '0;
        end else if (tick) begin
            presc <= '0;
            digit <= digit + 2'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of a 4-digit multiplexed seven-segment display; grants
// move only on scan-frame boundaries. Optional macro DP_OWNER_EN lights dp on the owner's digit.
//
//   state     | meaning
//   ARB_IDLE  | no owner, scan counters held, display blank
//   ARB_GRANT | owner scanning; arbitration re-evaluated at each frame boundary
module seg_display_arbiter
    import seg_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int SCAN_DIV     = 4096,
    parameter int DWELL_FRAMES = 256
) (
    input  logic                   i_CLK,
    input  logic                   i_RST,
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [16*NUM_REQ-1:0]  i_data,
    output logic [NUM_REQ-1:0]     o_gnt,
    output logic [3:0]             o_drains,
    output logic [7:0]             o_leds,
    output logic                   o_frame
);
    localparam int DWW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam logic [DWW-1:0] DWELL_MAX = DWW'(DWELL_FRAMES - 1);

    arb_state_t     state, state_n;
    logic [1:0]     owner, owner_n, ptr, ptr_n, owner_inc;
    logic [DWW-1:0] dwell, dwell_n;
    logic [1:0]     digit, digit_n;
    logic           tick, frame_bnd;
    logic           load, blank, frame_n;
    logic [3:0]     req4, others;
    logic [15:0]    data_arr [4];
    logic [15:0]    owner_data;
    logic [3:0]     nib;
    logic           dp;
    logic [NUM_REQ-1:0] gnt_n;

    assign req4 = 4'(i_req);

    for (genvar k = 0; k < 4; k++) begin : g_data
        if (k < NUM_REQ) begin : g_live
            assign data_arr[k] = i_data[16*k +: 16];
        end else begin : g_absent
            assign data_arr[k] = '0;
        end
    end

    seg_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
        .clk       (i_CLK),
        .rst       (i_RST),
        .run       (state == ARB_GRANT),
        .restart   ((state == ARB_IDLE) && (|req4)),
        .digit     (digit),
        .tick      (tick),
        .frame_bnd (frame_bnd)
    );

    assign owner_inc = (owner == 2'(NUM_REQ - 1)) ? 2'd0 : owner + 2'd1;
    assign others    = req4 & ~(4'b0001 << owner);

    // From idle the search includes the pointer itself, so the first grant
    // after reset goes to requester 0 when it is asking.
    always_comb begin
        state_n = state;
        owner_n = owner;
        ptr_n   = ptr;
        dwell_n = dwell;
        digit_n = digit;
        load    = 1'b0;
        blank   = 1'b0;
        frame_n = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (|req4) begin
                    state_n = ARB_GRANT;
                    owner_n = rr_pick(req4, ptr, NUM_REQ);
                    ptr_n   = owner_n;
                    dwell_n = '0;
                    digit_n = 2'd0;
                    load    = 1'b1;
                end
            end
            ARB_GRANT: begin
                if (tick) begin
                    load    = 1'b1;
                    digit_n = digit + 2'd1;
                end
                if (frame_bnd) begin
                    if (req4 == 4'b0000) begin
                        state_n = ARB_IDLE;
                        blank   = 1'b1;
                        dwell_n = '0;
                    end else begin
                        frame_n = 1'b1;
                        if (!req4[owner]) begin
                            owner_n = rr_pick(req4, owner_inc, NUM_REQ);
                            dwell_n = '0;
                        end else if (dwell == DWELL_MAX && others != 4'b0000) begin
                            owner_n = rr_pick(req4, owner_inc, NUM_REQ);
                            dwell_n = '0;
                        end else if (dwell != DWELL_MAX) begin
                            dwell_n = dwell + DWW'(1);
                        end
                        ptr_n = owner_n;
                    end
                end
            end
            default: state_n = ARB_IDLE;
        endcase
    end

    assign owner_data = data_arr[owner_n];
    assign nib        = owner_data[{digit_n, 2'b00} +: 4];
    assign gnt_n      = NUM_REQ'(4'b0001 << owner_n);

`ifdef DP_OWNER_EN
    assign dp = (digit_n == owner_n);
`else
    assign dp = 1'b0;
`endif

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state    <= ARB_IDLE;
            owner    <= '0;
            ptr      <= '0;
            dwell    <= '0;
            o_gnt    <= '0;
            o_drains <= '0;
            o_leds   <= '0;
            o_frame  <= 1'b0;
        end else begin
            state   <= state_n;
            owner   <= owner_n;
            ptr     <= ptr_n;
            dwell   <= dwell_n;
            o_frame <= frame_n;
            if (blank) begin
                o_gnt    <= '0;
                o_drains <= '0;
                o_leds   <= '0;
            end else if (load) begin
                o_gnt    <= gnt_n;
                o_drains <= DIGIT_ONEHOT[digit_n];
                o_leds   <= {dp, SEG_HEX[nib]};
            end
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench for seg_display_arbiter (NUM_REQ=4, SCAN_DIV=4, DWELL_FRAMES=2).
module tb_seg_display_arbiter;
    logic        i_CLK = 1'b0;
    logic        i_RST = 1'b1;
    logic [3:0]  i_req = '0;
    logic [63:0] i_data = '0;
    logic [3:0]  o_gnt;
    logic [3:0]  o_drains;
    logic [7:0]  o_leds;
    logic        o_frame;

    seg_display_arbiter #(.NUM_REQ(4), .SCAN_DIV(4), .DWELL_FRAMES(2)) dut (
        .i_CLK    (i_CLK),
        .i_RST    (i_RST),
        .i_req    (i_req),
        .i_data   (i_data),
        .o_gnt    (o_gnt),
        .o_drains (o_drains),
        .o_leds   (o_leds),
        .o_frame  (o_frame)
    );

    always #5 i_CLK = ~i_CLK;

    typedef struct {
        logic [3:0] gnt;
        logic [3:0] drains;
        logic [7:0] leds;
        logic       frame;
    } exp_t;

    typedef struct {
        int          k;
        logic [15:0] data;
        logic [31:0] leds;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    exp_t  exp_q [$];
    int    n_cmp = 0;
    int    n_bad = 0;
    string tag   = "init";

    logic [7:0] hex_tb [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    function automatic exp_t zero_exp();
        exp_t e;
        e.gnt = '0; e.drains = '0; e.leds = '0; e.frame = 1'b0;
        return e;
    endfunction

    // Expected outputs c cycles after the grant edge, owner k showing value d.
    function automatic exp_t own_exp(int k, logic [15:0] d, int c);
        exp_t       e;
        int         dg;
        logic [3:0] nb;
        dg       = (c / 4) % 4;
        nb       = d[4*dg +: 4];
        e.gnt    = 4'(1 << k);
        e.drains = 4'(1 << dg);
        e.leds   = hex_tb[nb];
`ifdef DP_OWNER_EN
        if (dg == k) e.leds[7] = 1'b1;
`endif
        e.frame  = (c > 0) && (c % 16 == 0);
        return e;
    endfunction

    task automatic cmp(string what, logic [7:0] got, logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s %s: got %h expected %h at %0t", tag, what, got, want, $time);
        end
    endtask

    task automatic check_now();
        exp_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            cmp("gnt",    8'(o_gnt),    8'(e.gnt));
            cmp("drains", 8'(o_drains), 8'(e.drains));
            cmp("leds",   o_leds,       e.leds);
            cmp("frame",  8'(o_frame),  8'(e.frame));
        end
    endtask

    task automatic step(exp_t e);
        exp_q.push_back(e);
        @(negedge i_CLK);
        check_now();
    endtask

    task automatic do_reset();
        i_req = '0;
        i_RST = 1'b1;
        @(negedge i_CLK);
        @(negedge i_CLK);
        i_RST = 1'b0;
    endtask

    initial begin
        vec_t        vecs [5];
        exp_t        e;
        int          dg;
        logic [15:0] d [4];

        vecs[0] = '{1, 16'h1234, {8'h06, 8'h5B, 8'h4F, 8'h66}};
        vecs[1] = '{0, 16'h89AB, {8'h7F, 8'h6F, 8'h77, 8'h7C}};
        vecs[2] = '{2, 16'hCDEF, {8'h39, 8'h5E, 8'h79, 8'h71}};
        vecs[3] = '{3, 16'h5670, {8'h6D, 8'h7D, 8'h07, 8'h3F}};
        vecs[4] = '{2, 16'h0000, {8'h3F, 8'h3F, 8'h3F, 8'h3F}};
        d[0] = 16'h0123; d[1] = 16'h4567; d[2] = 16'h89AB; d[3] = 16'hCDEF;

        // Reset state, then idle with no requests stays blank.
        tag = "reset";
        @(negedge i_CLK);
        exp_q.push_back(zero_exp());
        check_now();
        i_RST = 1'b0;
        for (int c = 0; c < 4; c++) step(zero_exp());

        // Asynchronous reset in the middle of a scan.
        tag = "rst_mid";
        i_data[15:0] = 16'h1234;
        i_req = 4'b0001;
        for (int c = 0; c < 7; c++) step(own_exp(0, 16'h1234, c));
        @(posedge i_CLK);
        #1 i_RST = 1'b1;
        i_req = '0;
        #1;
        exp_q.push_back(zero_exp());
        check_now();
        @(negedge i_CLK);
        i_RST = 1'b0;
        for (int c = 0; c < 6; c++) step(zero_exp());

        // Single owner, hex decode and scan order per table entry.
        foreach (vecs[i]) begin
            tag = $sformatf("vec%0d", i);
            do_reset();
            i_data = '0;
            i_data[16*vecs[i].k +: 16] = vecs[i].data;
            i_req = 4'(1 << vecs[i].k);
            for (int c = 0; c < 20; c++) begin
                dg       = (c / 4) % 4;
                e.gnt    = 4'(1 << vecs[i].k);
                e.drains = 4'(1 << dg);
                e.leds   = vecs[i].leds[8*dg +: 8];
`ifdef DP_OWNER_EN
                if (dg == vecs[i].k) e.leds[7] = 1'b1;
`endif
                e.frame  = (c == 16);
                step(e);
            end
        end

        // All requesting: two frames each, rotating 0,1,2,3,0.
        tag = "rotate";
        do_reset();
        i_data = {d[3], d[2], d[1], d[0]};
        i_req  = 4'b1111;
        for (int c = 0; c < 160; c++) step(own_exp((c / 32) % 4, d[(c / 32) % 4], c));

        // Owner drops mid-frame: grant held to the boundary; then all drop.
        tag = "drop";
        do_reset();
        i_data = {d[3], d[2], d[1], d[0]};
        i_req  = 4'b0001;
        for (int c = 0; c < 35; c++) begin
            if (c < 16)      step(own_exp(0, d[0], c));
            else if (c < 32) step(own_exp(2, d[2], c));
            else             step(zero_exp());
            if (c == 5)  i_req = 4'b0100;
            if (c == 20) i_req = 4'b0000;
        end

        // Lone requester across dwell expiry: steady grant, clean scan.
        tag = "lone";
        do_reset();
        i_data = '0;
        i_data[15:0] = 16'hA5C3;
        i_req = 4'b0001;
        for (int c = 0; c <= 160; c++) step(own_exp(0, 16'hA5C3, c));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
